// File: rtl/dff_ram_arbiter_if.sv
// Requester-side bundle for dff_ram_arbiter: two command ports plus the shared read-response bus.
// The master modport is used by the requesters and the slave modport by the arbiter.
interface dff_ram_arbiter_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 72
);
    logic              r0_valid;
    logic              r0_ready;
    logic              r0_wr;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r1_valid;
    logic              r1_ready;
    logic              r1_wr;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output r0_valid, r0_wr, r0_addr, r0_wdata,
        output r1_valid, r1_wr, r1_addr, r1_wdata,
        input  r0_ready, r1_ready, rsp0_valid, rsp1_valid, rsp_data
    );

    modport slave (
        input  r0_valid, r0_wr, r0_addr, r0_wdata,
        input  r1_valid, r1_wr, r1_addr, r1_wdata,
        output r0_ready, r1_ready, rsp0_valid, rsp1_valid, rsp_data
    );
endinterface

// File: rtl/dff_ram_arbiter.sv
// Two-port arbiter in front of a registered DFF RAM; read data returns to its issuer at latency 2.
// Define DFF_RAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module dff_ram_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 72
) (
    input  logic              clk,
    input  logic              rst,
    dff_ram_arbiter_if.slave  bus,
    output logic              ram_enb_o,
    output logic              ram_wr_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);
    logic              grant0;
    logic              grant1;
    logic              ram_enb_q, ram_enb_d;
    logic              ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              tag_vld_p1_q, tag_vld_p1_d;
    logic              tag_port_p1_q, tag_port_p1_d;
    logic              rsp0_vld_p2_q, rsp0_vld_p2_d;
    logic              rsp1_vld_p2_q, rsp1_vld_p2_d;
`ifndef DFF_RAM_ARB_FIXED_PRIO_EN
    logic              ptr_q, ptr_d;
`endif

    // Stage p0: combinational grant; ptr_q names the port that wins a conflict.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
`ifdef DFF_RAM_ARB_FIXED_PRIO_EN
            grant0 = bus.r0_valid;
            grant1 = bus.r1_valid && !bus.r0_valid;
`else
            grant0 = bus.r0_valid && (!bus.r1_valid || !ptr_q);
            grant1 = bus.r1_valid && (!bus.r0_valid || ptr_q);
`endif
        end
    end

    assign bus.r0_ready = grant0;
    assign bus.r1_ready = grant1;

    always_comb begin
        ram_enb_d     = grant0 || grant1;
        ram_wr_d      = ram_wr_q;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        tag_vld_p1_d  = 1'b0;
        tag_port_p1_d = grant1;
        if (grant0) begin
            ram_wr_d     = bus.r0_wr;
            ram_addr_d   = bus.r0_addr;
            ram_data_d   = bus.r0_wdata;
            tag_vld_p1_d = !bus.r0_wr;
        end else if (grant1) begin
            ram_wr_d     = bus.r1_wr;
            ram_addr_d   = bus.r1_addr;
            ram_data_d   = bus.r1_wdata;
            tag_vld_p1_d = !bus.r1_wr;
        end
        // Stage p1 -> p2: the tag moves alongside the RAM's own read register.
        rsp0_vld_p2_d = tag_vld_p1_q && !tag_port_p1_q;
        rsp1_vld_p2_d = tag_vld_p1_q && tag_port_p1_q;
    end

`ifndef DFF_RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        ptr_d = ptr_q;
        if (grant0) begin
            ptr_d = 1'b1;
        end else if (grant1) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_enb_q     <= 1'b0;
            ram_wr_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            tag_vld_p1_q  <= 1'b0;
            tag_port_p1_q <= 1'b0;
            rsp0_vld_p2_q <= 1'b0;
            rsp1_vld_p2_q <= 1'b0;
        end else begin
            ram_enb_q     <= ram_enb_d;
            ram_wr_q      <= ram_wr_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            tag_vld_p1_q  <= tag_vld_p1_d;
            tag_port_p1_q <= tag_port_p1_d;
            rsp0_vld_p2_q <= rsp0_vld_p2_d;
            rsp1_vld_p2_q <= rsp1_vld_p2_d;
        end
    end

    assign ram_enb_o      = ram_enb_q;
    assign ram_wr_o       = ram_wr_q;
    assign ram_addr_o     = ram_addr_q;
    assign ram_data_o     = ram_data_q;
    assign bus.rsp0_valid = rsp0_vld_p2_q;
    assign bus.rsp1_valid = rsp1_vld_p2_q;
    assign bus.rsp_data   = ram_rdata_i;
endmodule
